gf128_reduce_pipe: RTL and testbench
====================================

GF128_REDUCE_PIPE -- requirements
Module: gf128_reduce_pipe

Interface
REQ-001 SHALL have ports: clk input 1 (rising-edge clock).
REQ-002 SHALL have ports: rst input 1 (asynchronous, active-high reset; one clock domain only).
REQ-003 SHALL have ports: in_valid input 1 (upstream product valid).
REQ-004 SHALL have ports: in_ready output 1 (block can accept a product this cycle).
REQ-005 SHALL have ports: in_product input 256 (unreduced carry-less product from the GF(2^128) multiplier, bit i = coefficient of x^i).
REQ-006 SHALL have ports: out_valid output 1 (reduced result valid).
REQ-007 SHALL have ports: out_ready input 1 (downstream accepts the result).
REQ-008 SHALL have ports: out_result output 128 (in_product mod P(x), P(x) = x^128 + x^7 + x^2 + x + 1).
REQ-009 SHALL, with GF128_REDUCE_CNT_EN defined, add port: op_count output 32 (number of completed output transfers).

Function
REQ-010 SHALL accept an input on a rising edge where in_valid && in_ready, and deliver on a rising edge where out_valid && out_ready.
REQ-011 SHALL implement two pipeline registers. Stage 1 holds s1 = L ^ t[127:0] and o = t[134:128], where H = p[255:128], L = p[127:0], and t = H ^ (H<<1) ^ (H<<2) ^ (H<<7) at 135 bits. Stage 2 holds r = s1 ^ o ^ (o<<1) ^ (o<<2) ^ (o<<7) at 128 bits.
REQ-012 SHALL give 2-cycle latency. For a product accepted at edge N with out_ready held 1, out_valid=1 and out_result are valid in the cycle following edge N+1.
REQ-013 SHALL sustain throughput of one result per cycle while out_ready=1.
REQ-014 SHALL load stage 2 when stage 2 is empty or is being drained (out_ready=1) in the same cycle. Stage 1 SHALL load when stage 1 is empty or is advancing into stage 2.
REQ-015 SHALL drive in_ready = !s1_valid || (stage 1 advancing). This is combinational from out_ready, with no register in the ready path.
REQ-016 SHALL hold out_result and out_valid stable while out_valid=1 and out_ready=0. No data SHALL be lost or duplicated.
REQ-017 SHALL hold at most 2 products internally. With out_ready=0 and both stages full, in_ready SHALL be 0.
REQ-018 SHALL accept a new input in the same cycle that the output is drained when both stages are full, with no bubble.
REQ-019 SHALL ignore in_product when in_valid=0. Stage registers SHALL not change for a non-accepted input.
REQ-020 SHALL deliver results in acceptance order.

Reset
REQ-021 SHALL, on rst=1 asynchronously, clear s1_valid and s2_valid. This forces out_valid=0, in_ready=1, out_result=0, and op_count=0 when present.
REQ-022 SHALL discard any in-flight products on reset mid-operation. No output SHALL appear for them after rst deasserts.
REQ-023 SHALL accept input on the first rising edge after rst deasserts.

Configuration
REQ-024 SHALL, with macro GF128_REDUCE_CNT_EN defined, include op_count. op_count SHALL increment by 1 on every out_valid && out_ready edge and wrap from 0xFFFFFFFF to 0.
REQ-025 SHALL, without GF128_REDUCE_CNT_EN, omit the op_count port and counter logic entirely. Datapath and handshake behaviour SHALL be identical in both builds.

Verification
REQ-026 SHALL be verified by: in_product = 256'h1, out_ready=1 -> out_result = 128'h1 exactly 2 cycles after acceptance.
REQ-027 SHALL be verified by: in_product = 1<<128 -> out_result = 128'h87. Also in_product = 1<<254 -> out_result = 128'hC0000000_00000000_00000000_00001067.
REQ-028 SHALL be verified by: out_ready=0, present 3 back-to-back products -> 2 accepted and in_ready=0 on the third. Then set out_ready=1 -> three results appear in order on consecutive cycles, with the third accepted in the same cycle as the first drain.
REQ-029 SHALL be verified by: 500 random a,b driven through the multiplier into this block with random out_ready -> every out_result equals the bitwise shift-and-XOR golden a*b mod P(x), and none are dropped or duplicated.
REQ-030 SHALL be verified by: assert rst with both stages full -> out_valid=0 immediately, no stale result after release. With GF128_REDUCE_CNT_EN, op_count=0 after reset and equals 500 after the random run.

Source files
------------

// File: rtl/gf128_reduce_pipe.sv
// gf128_reduce_pipe: two-stage pipelined reduction of a 256-bit carry-less
// product modulo P(x) = x^128 + x^7 + x^2 + x + 1, with valid/ready handshake
// on both sides and a skid-free ready path (in_ready is combinational from
// out_ready).
//
// Stage 1 folds the upper half into the lower half once, leaving a 7-bit
// overflow o; stage 2 folds o back in to produce the final 128-bit residue.
//
// Optional build macro: GF128_REDUCE_CNT_EN adds the 32-bit op_count output,
// which counts completed output transfers and wraps to 0.
module gf128_reduce_pipe (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] in_product,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_result
`ifdef GF128_REDUCE_CNT_EN
   ,
   output logic [31:0]  op_count
`endif
);

   logic         s1_valid_q, s1_valid_d;
   logic [127:0] s1_data_q,  s1_data_d;
   logic [6:0]   s1_ovf_q,   s1_ovf_d;
   logic         s2_valid_q, s2_valid_d;
   logic [127:0] s2_data_q,  s2_data_d;

   logic         s2_load;
   logic         s1_adv;
   logic         in_fire;

   logic [127:0] hi;
   logic [127:0] lo;
   logic [134:0] fold_t;
   logic [127:0] fold_r;

   // Handshake: stage 2 takes new data when empty or draining; stage 1 frees up when it advances.
   always_comb begin
      s2_load  = !s2_valid_q || out_ready;
      s1_adv   = s1_valid_q && s2_load;
      in_ready = !s1_valid_q || s1_adv;
      in_fire  = in_valid && in_ready;
   end

   // First fold: t = H*(x^7 + x^2 + x + 1), 135 bits wide.
   always_comb begin
      hi     = in_product[255:128];
      lo     = in_product[127:0];
      fold_t = {7'b0, hi}
             ^ {6'b0, hi, 1'b0}
             ^ {5'b0, hi, 2'b0}
             ^ {hi, 7'b0};
      s1_data_d = lo ^ fold_t[127:0];
      s1_ovf_d  = fold_t[134:128];
   end

   // Second fold: the 7-bit overflow times (x^7 + x^2 + x + 1) fits in 14 bits, so no further carry.
   always_comb begin
      fold_r = s1_data_q
             ^ {121'b0, s1_ovf_q}
             ^ {120'b0, s1_ovf_q, 1'b0}
             ^ {119'b0, s1_ovf_q, 2'b0}
             ^ {114'b0, s1_ovf_q, 7'b0};
      s2_data_d = fold_r;
   end

   // Next-state valid bits for both stages.
   always_comb begin
      s1_valid_d = s1_valid_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end
      s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
   end

   // Stage 1 register: data only moves on an accepted input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_ovf_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (in_fire) begin
            s1_data_q <= s1_data_d;
            s1_ovf_q  <= s1_ovf_d;
         end
      end
   end

   // Stage 2 register: data only moves when stage 1 advances, so a stalled output stays stable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
      end else begin
         s2_valid_q <= s2_valid_d;
         if (s1_adv) begin
            s2_data_q <= s2_data_d;
         end
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_result = s2_data_q;

`ifdef GF128_REDUCE_CNT_EN
   logic        out_fire;
   logic [31:0] op_count_q, op_count_d;

   // Completed-transfer counter, wraps naturally at 32 bits.
   always_comb begin
      out_fire   = s2_valid_q && out_ready;
      op_count_d = out_fire ? op_count_q + 32'd1 : op_count_q;
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count_q <= '0;
      end else begin
         op_count_q <= op_count_d;
      end
   end

   assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_gf128_reduce_pipe.sv
// Testbench for gf128_reduce_pipe: directed vectors, backpressure and reset
// scenarios, then a randomized multiply-and-reduce run against a
// shift-and-XOR GF(2^128) reference.
module tb_gf128_reduce_pipe;

   localparam logic [255:0] POLY = {127'b0, 1'b1, 120'b0, 8'h87};

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] in_product;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_result;
`ifdef GF128_REDUCE_CNT_EN
   logic [31:0]  op_count;
`endif

   int tests_run = 0;
   int fails     = 0;

   gf128_reduce_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_product (in_product),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result)
`ifdef GF128_REDUCE_CNT_EN
      ,
      .op_count   (op_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [255:0] rand256();
      return {rand128(), rand128()};
   endfunction

   // Polynomial long division: cancel every bit at or above x^128.
   function automatic logic [127:0] reduce_ref(input logic [255:0] p);
      logic [255:0] v;
      v = p;
      for (int i = 255; i >= 128; i--) begin
         if (v[i]) v = v ^ (POLY << (i - 128));
      end
      return v[127:0];
   endfunction

   function automatic logic [255:0] clmul(input logic [127:0] a, input logic [127:0] b);
      logic [255:0] p;
      p = '0;
      for (int i = 0; i < 128; i++) begin
         if (b[i]) p = p ^ ({128'b0, a} << i);
      end
      return p;
   endfunction

   // Horner-style multiply with reduction on every doubling.
   function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
      logic [127:0] r;
      r = '0;
      for (int i = 127; i >= 0; i--) begin
         r = {r[126:0], 1'b0} ^ (r[127] ? 128'h87 : 128'h0);
         if (b[i]) r = r ^ a;
      end
      return r;
   endfunction

   // Send one product with out_ready=1; report result and edges from acceptance to visibility.
   task automatic run_one(input logic [255:0] p, output logic [127:0] res,
                          output int lat, output bit ok);
      bit acc;
      ok  = 1'b0;
      acc = 1'b0;
      lat = 0;
      res = '0;
      in_valid   = 1'b1;
      in_product = p;
      out_ready  = 1'b1;
      for (int n = 0; n < 20 && !acc; n++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
      end
      in_valid   = 1'b0;
      in_product = '0;
      if (acc) begin
         lat = 1;
         for (int n = 0; n < 20 && !ok; n++) begin
            if (out_valid) begin
               ok  = 1'b1;
               res = out_result;
            end else begin
               @(posedge clk); #1;
               lat++;
            end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [127:0] lo;
      logic [127:0] res;
      int           lat;
      bit           ok;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_product = '0;
      #2;
      tests_run++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      tests_run++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      tests_run++;
      if (out_result !== 128'h0) begin fails++; $display("FAIL reset_out_result: got %h expected 0", out_result); end
`ifdef GF128_REDUCE_CNT_EN
      tests_run++;
      if (op_count !== 32'd0) begin fails++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
`endif
      @(negedge clk);
      rst = 1'b0;
      // First edge after release must accept.
      lo = rand128();
      in_valid = 1'b1; in_product = {128'b0, lo}; out_ready = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL first_edge_ready: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL first_edge_early: got %b expected 0", out_valid); end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_result !== lo) begin
         fails++; $display("FAIL first_edge_result: got v=%b %h expected v=1 %h", out_valid, out_result, lo);
      end
      @(posedge clk); #1;
      run_one(256'h0, res, lat, ok);
   endtask

   task automatic test_vectors();
      logic [127:0] res;
      logic [255:0] p;
      int           lat;
      bit           ok;
      run_one(256'h1, res, lat, ok);
      tests_run++;
      if (!ok || res !== 128'h1) begin fails++; $display("FAIL vec_one: got ok=%b %h expected 1", ok, res); end
      tests_run++;
      if (lat !== 2) begin fails++; $display("FAIL vec_latency: got %0d expected 2", lat); end
      run_one(256'h1 << 128, res, lat, ok);
      tests_run++;
      if (!ok || res !== 128'h87) begin fails++; $display("FAIL vec_x128: got ok=%b %h expected 87", ok, res); end
      run_one(256'h1 << 254, res, lat, ok);
      tests_run++;
      if (!ok || res !== 128'hC0000000_00000000_00000000_00001067) begin
         fails++; $display("FAIL vec_x254: got ok=%b %h expected c0000000000000000000000000001067", ok, res);
      end
      for (int k = 0; k < 4; k++) begin
         p = rand256();
         run_one(p, res, lat, ok);
         tests_run++;
         if (!ok || res !== reduce_ref(p)) begin
            fails++; $display("FAIL vec_rand%0d: got ok=%b %h expected %h", k, ok, res, reduce_ref(p));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [255:0] p0, p1, p2;
      p0 = rand256(); p1 = rand256(); p2 = rand256();
      out_ready = 1'b0;
      in_valid = 1'b1; in_product = p0;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_accept0: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      in_product = p1;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_accept1: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      in_product = p2;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
      tests_run++;
      if (out_valid !== 1'b1 || out_result !== reduce_ref(p0)) begin
         fails++; $display("FAIL bp_head: got v=%b %h expected v=1 %h", out_valid, out_result, reduce_ref(p0));
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_result !== reduce_ref(p0) || in_ready !== 1'b0) begin
         fails++; $display("FAIL bp_hold: got v=%b rdy=%b %h expected v=1 rdy=0 %h", out_valid, in_ready, out_result, reduce_ref(p0));
      end
      out_ready = 1'b1;
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_drain_accept: got %b expected 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; in_product = '0;
      tests_run++;
      if (out_valid !== 1'b1 || out_result !== reduce_ref(p1)) begin
         fails++; $display("FAIL bp_second: got v=%b %h expected v=1 %h", out_valid, out_result, reduce_ref(p1));
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_result !== reduce_ref(p2)) begin
         fails++; $display("FAIL bp_third: got v=%b %h expected v=1 %h", out_valid, out_result, reduce_ref(p2));
      end
      @(posedge clk); #1;
      tests_run++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
   endtask

   task automatic test_reset_midflight();
      bit stale;
      out_ready = 1'b0;
      in_valid = 1'b1; in_product = rand256();
      @(posedge clk); #1;
      in_product = rand256();
      @(posedge clk); #1;
      in_valid = 1'b0; in_product = '0;
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         fails++; $display("FAIL mid_full: got v=%b rdy=%b expected v=1 rdy=0", out_valid, in_ready);
      end
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 128'h0) begin
         fails++; $display("FAIL mid_async: got v=%b rdy=%b %h expected v=0 rdy=1 0", out_valid, in_ready, out_result);
      end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      stale = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) stale = 1'b1;
      end
      tests_run++;
      if (stale !== 1'b0) begin fails++; $display("FAIL mid_stale: got stale output 1 expected 0"); end
`ifdef GF128_REDUCE_CNT_EN
      tests_run++;
      if (op_count !== 32'd0) begin fails++; $display("FAIL mid_op_count: got %0d expected 0", op_count); end
`endif
   endtask

   task automatic test_random();
      logic [127:0] expq[$];
      logic [127:0] a, b, exp;
      int           sent, received, cyc;
      bit           idle_bad;
      sent = 0; received = 0; cyc = 0;
      a = '0; b = '0;
      while (received < 500 && cyc < 20000) begin
         a = rand128();
         b = rand128();
         in_valid   = (sent < 500) && ($urandom_range(0, 9) < 6);
         in_product = clmul(a, b);
         out_ready  = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (in_valid && in_ready) begin
            expq.push_back(gf_mul(a, b));
            sent++;
         end
         if (out_valid && out_ready) begin
            tests_run++;
            if (expq.size() == 0) begin
               fails++; $display("FAIL rnd_extra: got unexpected %h expected nothing", out_result);
            end else begin
               exp = expq.pop_front();
               if (out_result !== exp) begin
                  fails++; $display("FAIL rnd_result%0d: got %h expected %h", received, out_result, exp);
               end
            end
            received++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; in_product = '0;
      tests_run++;
      if (received !== 500 || expq.size() !== 0) begin
         fails++; $display("FAIL rnd_count: got %0d received %0d pending expected 500 and 0", received, expq.size());
      end
`ifdef GF128_REDUCE_CNT_EN
      tests_run++;
      if (op_count !== 32'd500) begin fails++; $display("FAIL rnd_op_count: got %0d expected 500", op_count); end
`endif
      out_ready = 1'b1;
      idle_bad = 1'b0;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) idle_bad = 1'b1;
      end
      tests_run++;
      if (idle_bad !== 1'b0) begin fails++; $display("FAIL rnd_duplicate: got extra output 1 expected 0"); end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
